// File: rtl/basicparams_pkg.sv
// Shared definitions for the cache arbiter: FSM state encoding and grant encoding.
package basicparams;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2,
        DRAIN  = 2'd3
    } ArbState;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// Two-port (instruction/data) arbiter onto one memory port with a single outstanding
// transaction; killed instruction fetches have their response swallowed in DRAIN.
module cache_arbiter
    import basicparams::*;
#(
    parameter int unsigned DATA_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    input  logic        i_wen,
    input  logic [31:0] i_wdata,
    input  logic        i_kill,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic        d_wen,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_rdata,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic        m_wen,
    output logic [31:0] m_wdata,
    input  logic        m_resp_valid,
    input  logic [31:0] m_resp_rdata
);

    ArbState state_reg;
    ArbState state_next;
    logic    last_grant_reg;
    logic    last_grant_next;

    logic    free;
    logic    i_elig;
    logic    d_elig;
    logic    grant;
    logic    accept;

    // On a tie, round-robin favours the side that did not win last time.
    function automatic logic select_grant(input logic inst_ok,
                                          input logic data_ok,
                                          input logic last);
        logic g;
        g = GRANT_I;
        if (data_ok && !inst_ok) begin
            g = GRANT_D;
        end else if (data_ok && inst_ok) begin
            if (DATA_FIRST != 0) begin
                g = GRANT_D;
            end else begin
                g = (last == GRANT_D) ? GRANT_I : GRANT_D;
            end
        end
        return g;
    endfunction

    assign free   = (state_reg == IDLE) || m_resp_valid;
    assign i_elig = i_valid && !i_kill;
    assign d_elig = d_valid;
    assign grant  = select_grant(i_elig, d_elig, last_grant_reg);

    assign m_valid = free && (i_elig || d_elig);
    assign accept  = m_valid && m_ready;

    assign m_addr  = !m_valid ? 32'd0 : (grant == GRANT_D) ? d_addr  : i_addr;
    assign m_wen   = !m_valid ? 1'b0  : (grant == GRANT_D) ? d_wen   : i_wen;
    assign m_wdata = !m_valid ? 32'd0 : (grant == GRANT_D) ? d_wdata : i_wdata;

    assign i_ready = accept && (grant == GRANT_I);
    assign d_ready = accept && (grant == GRANT_D);

    // Responses bypass straight through; a kill in the response cycle suppresses it.
    assign i_resp_valid = (state_reg == WAIT_I) && m_resp_valid && !i_kill;
    assign d_resp_valid = (state_reg == WAIT_D) && m_resp_valid;
    assign i_resp_rdata = i_resp_valid ? m_resp_rdata : 32'd0;
    assign d_resp_rdata = d_resp_valid ? m_resp_rdata : 32'd0;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        if (accept) begin
            state_next      = (grant == GRANT_D) ? WAIT_D : WAIT_I;
            last_grant_next = grant;
        end else if (free) begin
            state_next = IDLE;
        end else if ((state_reg == WAIT_I) && i_kill) begin
            state_next = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_D;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

endmodule
